arcade_input_mapper: RTL and testbench
======================================

Name: arcade_input_mapper

Overview:
- Parametrised input front-end placed between hps_io and the game core (m72 and later boards).
- Replaces ad-hoc keyboard/joystick/DIP glue in the emu top with one block for N players and B buttons.
- Adds per-player SOCD cleaning, coin pulse stretching and DIP capture. All outputs are registered and active-low, matching core input conventions.

Parameters:
- NUM_PLAYERS, 2, number of player channels (1..4).
- NUM_BUTTONS, 4, fire buttons per player (1..8). Joystick bits 4..4+NUM_BUTTONS-1 feed them.
- NUM_DIP, 2, number of DIP bytes captured (1..8).
- COIN_MIN_CYCLES, 32'd320000, minimum coin assertion length in clk_sys cycles (10 ms at 32 MHz).
- KBD_ALL_PLAYERS, 1, 1 = keyboard drives every player, 0 = keyboard drives player 0 only.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ps2_key  in  11  hps_io key event: [10] toggle, [9] pressed, [8] extended (ignored), [7:0] scan code.
- joy_flat  in  16*NUM_PLAYERS  hps_io joysticks, player p at [16p+15:16p]. Bits: 0 R, 1 L, 2 D, 3 U, 4.. buttons, 8 start, 9 coin, 11 pause.
- socd_mode  in  2  0 pass-through, 1 opposing = neutral, 2 last-pressed wins, 3 reserved (treated as 0).
- ioctl_wr  in  1  download write strobe.
- ioctl_index  in  8  download index; DIP data uses index 254.
- ioctl_addr  in  25  download byte address.
- ioctl_dout  in  8  download byte.
- dir_n  out  4*NUM_PLAYERS  per player {U,D,L,R}, active-low.
- button_n  out  NUM_BUTTONS*NUM_PLAYERS  per player, button 0 in MSB position of its slice, active-low.
- start_n  out  NUM_PLAYERS  active-low start.
- coin_n  out  NUM_PLAYERS  active-low stretched coin.
- pause  out  1  active-high pause request.
- dip_sw  out  8*NUM_DIP  raw captured DIP bytes, byte i at [8i+7:8i].

Behaviour:
- Keyboard tracker: register old_toggle. An event is ps2_key[10] != old_toggle; pressed = ps2_key[9].
- Scan-code map (m72_pkg constants): 16 start1, 1E start2, 2E coin1, 36 coin2, 4D pause, 75 U, 72 D, 6B L, 74 R, 14 btn0, 11 btn1, 29 btn2, 12 btn3.
- Key codes for players or buttons beyond the parameters are ignored. Unmapped codes change nothing.
- Raw per player p: dir = kbd_dir (if KBD_ALL_PLAYERS or p==0) OR joy U/D/L/R. Buttons, start and coin are combined the same way.
- SOCD, per axis independently (U/D and L/R), sub-module socd_axis:
  - mode 0: raw value passes through.
  - mode 1: both raw bits set gives both 0.
  - mode 2: a 1-bit memory records the most recently rising direction. When both are set, only that direction is output.
  - The memory updates on the rising edge of either raw bit. If both rise in the same cycle, the positive direction (U/R) wins.
- Coin stretch, per player:
  - A rising edge of raw coin loads the counter with COIN_MIN_CYCLES-1 and asserts coin.
  - coin stays asserted while raw coin = 1 or counter != 0. The counter decrements to 0 and saturates there.
  - A new rising edge during stretch reloads the counter.
  - Counter width is $clog2(COIN_MIN_CYCLES+1).
- pause = kbd_pause OR any joy[11].
- DIP capture: on ioctl_wr && ioctl_index==254 && ioctl_addr[24:3]==0 && ioctl_addr[2:0]<NUM_DIP, dip byte [ioctl_addr[2:0]] <= ioctl_dout.
  - DIP bytes are NOT cleared by reset; they survive core reset. Power-up value is 8'h00.
- Latency:
  - joystick change to output: 1 cycle.
  - ps2 toggle to output: 2 cycles (key state register, then output register).
  - DIP: 1 cycle.
- Reset (synchronous):
  - old_toggle <= ps2_key[10], so no spurious event.
  - Key states, SOCD memories and coin counters cleared to 0.
  - dir_n/button_n/start_n/coin_n <= all ones; pause <= 0.
- Reset held mid-stretch: the counter clears and coin_n = 1 on the next cycle.
- Simultaneous ps2 event and reset: reset wins and the event is discarded.

Decomposition:
- m72_pkg gains typedef enum logic [1:0] socd_mode_t {SOCD_PASS, SOCD_NEUTRAL, SOCD_LAST, SOCD_RSVD}.
- m72_pkg gains localparams PS2_KEY_START1 … PS2_KEY_BTN3 and DIP_IOCTL_INDEX = 8'd254.
- One sub-module, socd_axis (clk_sys, reset, mode, raw_pos, raw_neg → out_pos, out_neg), instantiated twice per player in a generate loop.

Test Plan:
- Reset, then ps2_key toggle with code 75 pressed → dir_n[3] of player 0 (and player 1 with KBD_ALL_PLAYERS=1) goes 0 exactly 2 cycles later. Toggle with pressed=0 → returns to 1.
- socd_mode=1, joy_flat bits 0 and 1 set for player 0 → dir_n L and R both 1. socd_mode=2, L asserted then R asserted 5 cycles later → R=0, L=1. Release R → L=0.
- COIN_MIN_CYCLES=8, single-cycle joy bit 9 pulse → coin_n low for exactly 8 cycles. Second pulse at cycle 4 → low 8 cycles from the second pulse (12 total).
- ioctl_wr at index 254, addr 0 = 8'hA5, addr 1 = 8'h3C, addr 9 = 8'hFF → dip_sw = 16'h3CA5. Assert reset → dip_sw unchanged.
- Player-2 joystick bit 11 set → pause=1 after 1 cycle. ps2 code 4D pressed → pause stays 1 until both are released.
- Reset asserted during coin stretch with ps2 toggle in the same cycle → next cycle all active-low outputs all ones and pause=0. No key is latched after reset deasserts.

Source files
------------

// File: rtl/arcade_input_mapper_pkg.sv
// Shared constants for the arcade input front-end: PS/2 scan codes,
// SOCD mode encoding and the ioctl index that carries DIP bytes.
package m72_pkg;

   typedef enum logic [1:0] {
      SOCD_PASS,
      SOCD_NEUTRAL,
      SOCD_LAST,
      SOCD_RSVD
   } socd_mode_t;

   localparam logic [7:0] PS2_KEY_START1 = 8'h16;
   localparam logic [7:0] PS2_KEY_START2 = 8'h1E;
   localparam logic [7:0] PS2_KEY_COIN1  = 8'h2E;
   localparam logic [7:0] PS2_KEY_COIN2  = 8'h36;
   localparam logic [7:0] PS2_KEY_PAUSE  = 8'h4D;
   localparam logic [7:0] PS2_KEY_UP     = 8'h75;
   localparam logic [7:0] PS2_KEY_DOWN   = 8'h72;
   localparam logic [7:0] PS2_KEY_LEFT   = 8'h6B;
   localparam logic [7:0] PS2_KEY_RIGHT  = 8'h74;
   localparam logic [7:0] PS2_KEY_BTN0   = 8'h14;
   localparam logic [7:0] PS2_KEY_BTN1   = 8'h11;
   localparam logic [7:0] PS2_KEY_BTN2   = 8'h29;
   localparam logic [7:0] PS2_KEY_BTN3   = 8'h12;

   localparam logic [7:0] DIP_IOCTL_INDEX = 8'd254;

endpackage

// File: rtl/arcade_input_mapper_socd_axis.sv
// One joystick axis of SOCD cleaning. Output is combinational; the
// caller registers it together with the rest of the player outputs.
module socd_axis
   import m72_pkg::*;
(
   input  logic       i_clk_sys,
   input  logic       i_reset,
   input  socd_mode_t i_mode,
   input  logic       i_raw_pos,
   input  logic       i_raw_neg,
   output logic       o_out_pos,
   output logic       o_out_neg
);

   logic r_prev_pos;
   logic r_prev_neg;
   logic r_last_pos;
   logic w_rise_pos;
   logic w_rise_neg;
   logic w_last_pos;

   assign w_rise_pos = i_raw_pos & ~r_prev_pos;
   assign w_rise_neg = i_raw_neg & ~r_prev_neg;

   // Use the updated memory so a direction that rises this cycle wins at once.
   always_comb begin
      w_last_pos = r_last_pos;
      if (w_rise_pos)
         w_last_pos = 1'b1;
      else if (w_rise_neg)
         w_last_pos = 1'b0;
   end

   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_prev_pos <= 1'b0;
         r_prev_neg <= 1'b0;
         r_last_pos <= 1'b0;
      end else begin
         r_prev_pos <= i_raw_pos;
         r_prev_neg <= i_raw_neg;
         r_last_pos <= w_last_pos;
      end
   end

   always_comb begin
      o_out_pos = i_raw_pos;
      o_out_neg = i_raw_neg;
      if (i_raw_pos && i_raw_neg) begin
         case (i_mode)
            SOCD_NEUTRAL: begin
               o_out_pos = 1'b0;
               o_out_neg = 1'b0;
            end
            SOCD_LAST: begin
               o_out_pos = w_last_pos;
               o_out_neg = ~w_last_pos;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/arcade_input_mapper.sv
// Keyboard/joystick/DIP front-end for N players: merges PS/2 keys with
// hps_io joysticks, cleans SOCD, stretches coin pulses, captures DIP bytes.
module arcade_input_mapper
   import m72_pkg::*;
#(
   parameter int          NUM_PLAYERS     = 2,
   parameter int          NUM_BUTTONS     = 4,
   parameter int          NUM_DIP         = 2,
   parameter int unsigned COIN_MIN_CYCLES = 320000,
   parameter int          KBD_ALL_PLAYERS = 1
) (
   input  logic                               i_clk_sys,
   input  logic                               i_reset,
   input  logic [10:0]                        i_ps2_key,
   input  logic [16*NUM_PLAYERS-1:0]          i_joy_flat,
   input  logic [1:0]                         i_socd_mode,
   input  logic                               i_ioctl_wr,
   input  logic [7:0]                         i_ioctl_index,
   input  logic [24:0]                        i_ioctl_addr,
   input  logic [7:0]                         i_ioctl_dout,
   output logic [4*NUM_PLAYERS-1:0]           o_dir_n,
   output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] o_button_n,
   output logic [NUM_PLAYERS-1:0]             o_start_n,
   output logic [NUM_PLAYERS-1:0]             o_coin_n,
   output logic                               o_pause,
   output logic [8*NUM_DIP-1:0]               o_dip_sw
);

   localparam int CNT_W = $clog2(COIN_MIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] COIN_LOAD = CNT_W'(COIN_MIN_CYCLES - 1);

   socd_mode_t w_mode;
   assign w_mode = socd_mode_t'(i_socd_mode);

   logic       r_old_toggle;
   logic [3:0] r_kbd_dir;
   logic [3:0] r_kbd_btn;
   logic [1:0] r_kbd_start;
   logic [1:0] r_kbd_coin;
   logic       r_kbd_pause;
   logic       w_ps2_evt;

   assign w_ps2_evt = i_ps2_key[10] != r_old_toggle;

   // Resyncing old_toggle under reset swallows any event arriving with it.
   always_ff @(posedge i_clk_sys) begin
      r_old_toggle <= i_ps2_key[10];
      if (i_reset) begin
         r_kbd_dir   <= '0;
         r_kbd_btn   <= '0;
         r_kbd_start <= '0;
         r_kbd_coin  <= '0;
         r_kbd_pause <= 1'b0;
      end else if (w_ps2_evt) begin
         case (i_ps2_key[7:0])
            PS2_KEY_START1: r_kbd_start[0] <= i_ps2_key[9];
            PS2_KEY_START2: r_kbd_start[1] <= i_ps2_key[9];
            PS2_KEY_COIN1:  r_kbd_coin[0]  <= i_ps2_key[9];
            PS2_KEY_COIN2:  r_kbd_coin[1]  <= i_ps2_key[9];
            PS2_KEY_PAUSE:  r_kbd_pause    <= i_ps2_key[9];
            PS2_KEY_UP:     r_kbd_dir[3]   <= i_ps2_key[9];
            PS2_KEY_DOWN:   r_kbd_dir[2]   <= i_ps2_key[9];
            PS2_KEY_LEFT:   r_kbd_dir[1]   <= i_ps2_key[9];
            PS2_KEY_RIGHT:  r_kbd_dir[0]   <= i_ps2_key[9];
            PS2_KEY_BTN0:   r_kbd_btn[0]   <= i_ps2_key[9];
            PS2_KEY_BTN1:   r_kbd_btn[1]   <= i_ps2_key[9];
            PS2_KEY_BTN2:   r_kbd_btn[2]   <= i_ps2_key[9];
            PS2_KEY_BTN3:   r_kbd_btn[3]   <= i_ps2_key[9];
            default: ;
         endcase
      end
   end

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      localparam bit KBD_EN = (KBD_ALL_PLAYERS != 0) || (p == 0);

      logic [15:0]            w_joy;
      logic [3:0]             w_dir_raw;
      logic [3:0]             w_dir;
      logic [NUM_BUTTONS-1:0] w_btn_slot;
      logic                   w_start_raw;
      logic                   w_coin_raw;
      logic                   w_coin_rise;
      logic                   w_coin_on;
      logic                   r_coin_prev;
      logic [CNT_W-1:0]       r_coin_cnt;
      logic [3:0]             r_dir_n;
      logic [NUM_BUTTONS-1:0] r_btn_n;
      logic                   r_start_n;
      logic                   r_coin_n;

      assign w_joy     = i_joy_flat[16*p +: 16];
      assign w_dir_raw = w_joy[3:0] | (KBD_EN ? r_kbd_dir : 4'b0);

      // Button 0 lands in the MSB of the player's slice.
      for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
         if (KBD_EN && b < 4) begin : g_kbd
            assign w_btn_slot[NUM_BUTTONS-1-b] = w_joy[4+b] | r_kbd_btn[b];
         end else begin : g_joy
            assign w_btn_slot[NUM_BUTTONS-1-b] = w_joy[4+b];
         end
      end

      if (p < 2) begin : g_kstart
         assign w_start_raw = w_joy[8] | r_kbd_start[p];
         assign w_coin_raw  = w_joy[9] | r_kbd_coin[p];
      end else begin : g_jstart
         assign w_start_raw = w_joy[8];
         assign w_coin_raw  = w_joy[9];
      end

      socd_axis u_vert (
         .i_clk_sys (i_clk_sys),
         .i_reset   (i_reset),
         .i_mode    (w_mode),
         .i_raw_pos (w_dir_raw[3]),
         .i_raw_neg (w_dir_raw[2]),
         .o_out_pos (w_dir[3]),
         .o_out_neg (w_dir[2])
      );

      socd_axis u_horz (
         .i_clk_sys (i_clk_sys),
         .i_reset   (i_reset),
         .i_mode    (w_mode),
         .i_raw_pos (w_dir_raw[0]),
         .i_raw_neg (w_dir_raw[1]),
         .o_out_pos (w_dir[0]),
         .o_out_neg (w_dir[1])
      );

      assign w_coin_rise = w_coin_raw & ~r_coin_prev;
      assign w_coin_on   = w_coin_raw | (r_coin_cnt != '0);

      always_ff @(posedge i_clk_sys) begin
         if (i_reset) begin
            r_coin_prev <= 1'b0;
            r_coin_cnt  <= '0;
            r_dir_n     <= '1;
            r_btn_n     <= '1;
            r_start_n   <= 1'b1;
            r_coin_n    <= 1'b1;
         end else begin
            r_coin_prev <= w_coin_raw;
            if (w_coin_rise)
               r_coin_cnt <= COIN_LOAD;
            else if (r_coin_cnt != '0)
               r_coin_cnt <= r_coin_cnt - CNT_W'(1);
            r_dir_n   <= ~w_dir;
            r_btn_n   <= ~w_btn_slot;
            r_start_n <= ~w_start_raw;
            r_coin_n  <= ~w_coin_on;
         end
      end

      assign o_dir_n[4*p +: 4]                     = r_dir_n;
      assign o_button_n[NUM_BUTTONS*p +: NUM_BUTTONS] = r_btn_n;
      assign o_start_n[p]                          = r_start_n;
      assign o_coin_n[p]                           = r_coin_n;
   end

   logic w_joy_pause;
   logic r_pause;

   always_comb begin
      w_joy_pause = 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++)
         w_joy_pause = w_joy_pause | i_joy_flat[16*p+11];
   end

   always_ff @(posedge i_clk_sys) begin
      if (i_reset)
         r_pause <= 1'b0;
      else
         r_pause <= r_kbd_pause | w_joy_pause;
   end

   assign o_pause = r_pause;

   // DIP bytes deliberately have no reset so settings survive a core reset;
   // FPGA registers come up zero at configuration.
   logic [NUM_DIP-1:0][7:0] r_dip;
   logic                    w_dip_wr;

   assign w_dip_wr = i_ioctl_wr && (i_ioctl_index == DIP_IOCTL_INDEX) &&
                     (i_ioctl_addr[24:3] == '0);

   always_ff @(posedge i_clk_sys) begin
      for (int i = 0; i < NUM_DIP; i++)
         if (w_dip_wr && i_ioctl_addr[2:0] == 3'(i))
            r_dip[i] <= i_ioctl_dout;
   end

   assign o_dip_sw = r_dip;

   logic w_unused;
   assign w_unused = ^{i_ps2_key[8], i_joy_flat, r_kbd_btn, r_kbd_start, r_kbd_coin};

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// cycle by cycle against a timestamp-based behavioural model.
module tb_arcade_input_mapper;

  localparam int NP   = 3;
  localparam int NB   = 4;
  localparam int ND   = 2;
  localparam int CMIN = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [10:0]       ps2;
  logic [16*NP-1:0]  joy;
  logic [1:0]        mode;
  logic              wr;
  logic [7:0]        idx;
  logic [24:0]       addr;
  logic [7:0]        dout;
  logic [4*NP-1:0]   dir_n;
  logic [NB*NP-1:0]  btn_n;
  logic [NP-1:0]     start_n;
  logic [NP-1:0]     coin_n;
  logic              pause;
  logic [8*ND-1:0]   dip;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arcade_input_mapper #(
    .NUM_PLAYERS(NP), .NUM_BUTTONS(NB), .NUM_DIP(ND),
    .COIN_MIN_CYCLES(CMIN), .KBD_ALL_PLAYERS(1)
  ) dut (
    .i_clk_sys(clk), .i_reset(rst), .i_ps2_key(ps2), .i_joy_flat(joy),
    .i_socd_mode(mode), .i_ioctl_wr(wr), .i_ioctl_index(idx),
    .i_ioctl_addr(addr), .i_ioctl_dout(dout),
    .o_dir_n(dir_n), .o_button_n(btn_n), .o_start_n(start_n),
    .o_coin_n(coin_n), .o_pause(pause), .o_dip_sw(dip)
  );

  // ---------------- behavioural model ----------------
  bit   kdown [256];
  bit   old_tog;
  bit   prev_dir [NP][4];
  int   rise_t [NP][4];
  bit   prev_coin [NP];
  int   coin_t [NP];
  int   cyc = 0;
  logic [8*ND-1:0]  m_dip = '0;
  logic [4*NP-1:0]  e_dir_n;
  logic [NB*NP-1:0] e_btn_n;
  logic [NP-1:0]    e_start_n, e_coin_n;
  logic             e_pause;
  logic [7:0] btn_code [4] = '{8'h14, 8'h11, 8'h29, 8'h12};
  logic [7:0] st_code  [2] = '{8'h16, 8'h1E};
  logic [7:0] cn_code  [2] = '{8'h2E, 8'h36};

  function automatic void model_eval();
    logic [15:0] j;
    bit r [4];
    bit o [4];
    bit c, s;
    int pp, nn;
    cyc++;
    if (rst) begin
      foreach (kdown[i]) kdown[i] = 1'b0;
      for (int p = 0; p < NP; p++) begin
        for (int d = 0; d < 4; d++) begin prev_dir[p][d] = 1'b0; rise_t[p][d] = -1; end
        prev_coin[p] = 1'b0;
        coin_t[p] = -1000;
      end
      e_dir_n = '1; e_btn_n = '1; e_start_n = '1; e_coin_n = '1; e_pause = 1'b0;
      old_tog = ps2[10];
    end else begin
      e_pause = kdown[8'h4D];
      for (int p = 0; p < NP; p++) begin
        j = joy[16*p +: 16];
        r[0] = j[0] | kdown[8'h74];
        r[1] = j[1] | kdown[8'h6B];
        r[2] = j[2] | kdown[8'h72];
        r[3] = j[3] | kdown[8'h75];
        for (int d = 0; d < 4; d++) begin
          if (r[d] && !prev_dir[p][d]) rise_t[p][d] = cyc;
          prev_dir[p][d] = r[d];
          o[d] = r[d];
        end
        for (int ax = 0; ax < 2; ax++) begin
          pp = (ax == 0) ? 3 : 0;
          nn = (ax == 0) ? 2 : 1;
          if (r[pp] && r[nn]) begin
            if (mode == 2'd1) begin o[pp] = 1'b0; o[nn] = 1'b0; end
            else if (mode == 2'd2) begin
              if (rise_t[p][pp] >= rise_t[p][nn]) o[nn] = 1'b0; else o[pp] = 1'b0;
            end
          end
        end
        for (int d = 0; d < 4; d++) e_dir_n[4*p+d] = !o[d];
        for (int b = 0; b < NB; b++)
          e_btn_n[NB*p + NB-1-b] = !(j[4+b] | (b < 4 && kdown[btn_code[b]]));
        s = j[8] | (p < 2 && kdown[st_code[p < 2 ? p : 0]]);
        c = j[9] | (p < 2 && kdown[cn_code[p < 2 ? p : 0]]);
        e_start_n[p] = !s;
        if (c && !prev_coin[p]) coin_t[p] = cyc;
        prev_coin[p] = c;
        e_coin_n[p] = !(c || (cyc - coin_t[p] < CMIN));
        e_pause = e_pause | j[11];
      end
      if (ps2[10] != old_tog) kdown[ps2[7:0]] = ps2[9];
      old_tog = ps2[10];
    end
    if (wr && idx == 8'd254 && addr[24:3] == 0 && int'(addr[2:0]) < ND)
      m_dip[8*int'(addr[2:0]) +: 8] = dout;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_eval();
    @(negedge clk);
  endtask

  task automatic key(input logic [7:0] code, input bit pressed);
    ps2 = {~ps2[10], pressed, 1'b0, code};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (dir_n !== '1) begin bad++; $display("FAIL reset_dir got=%h exp=%h", dir_n, {4*NP{1'b1}}); end
    total++; if (btn_n !== '1) begin bad++; $display("FAIL reset_btn got=%h exp=%h", btn_n, {NB*NP{1'b1}}); end
    total++; if (start_n !== '1 || coin_n !== '1) begin bad++; $display("FAIL reset_start_coin got=%b/%b exp=all ones", start_n, coin_n); end
    total++; if (pause !== 1'b0) begin bad++; $display("FAIL reset_pause got=%b exp=0", pause); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_kbd_latency();
    key(8'h75, 1'b1);
    tick();
    total++; if (dir_n[3] !== 1'b1) begin bad++; $display("FAIL kbd_up_early got=%b exp=1", dir_n[3]); end
    tick();
    total++; if ({dir_n[11], dir_n[7], dir_n[3]} !== 3'b000) begin bad++; $display("FAIL kbd_up_2cyc got=%b exp=000", {dir_n[11], dir_n[7], dir_n[3]}); end
    total++; if (dir_n[2:0] !== 3'b111) begin bad++; $display("FAIL kbd_up_others got=%b exp=111", dir_n[2:0]); end
    key(8'h75, 1'b0);
    tick();
    total++; if (dir_n[3] !== 1'b0) begin bad++; $display("FAIL kbd_rel_early got=%b exp=0", dir_n[3]); end
    tick();
    total++; if (dir_n !== '1) begin bad++; $display("FAIL kbd_rel got=%h exp=fff", dir_n); end
  endtask

  task automatic test_socd();
    mode = 2'd1;
    joy[1:0] = 2'b11;
    tick();
    total++; if (dir_n[1:0] !== 2'b11) begin bad++; $display("FAIL socd_neutral got=%b exp=11", dir_n[1:0]); end
    joy[1:0] = 2'b00; mode = 2'd2;
    tick(); tick();
    joy[1] = 1'b1;
    tick();
    total++; if (dir_n[1:0] !== 2'b01) begin bad++; $display("FAIL socd_left_only got=%b exp=01", dir_n[1:0]); end
    tick(); tick(); tick(); tick();
    joy[0] = 1'b1;
    tick();
    total++; if (dir_n[1:0] !== 2'b10) begin bad++; $display("FAIL socd_last_right got=%b exp=10", dir_n[1:0]); end
    tick();
    total++; if (dir_n[1:0] !== 2'b10) begin bad++; $display("FAIL socd_last_hold got=%b exp=10", dir_n[1:0]); end
    joy[0] = 1'b0;
    tick();
    total++; if (dir_n[1:0] !== 2'b01) begin bad++; $display("FAIL socd_release_r got=%b exp=01", dir_n[1:0]); end
    joy[3:0] = 4'b1100;
    tick();
    total++; if (dir_n[3:2] !== 2'b01) begin bad++; $display("FAIL socd_tie_up got=%b exp=01", dir_n[3:2]); end
    joy[3:0] = 4'b0000; mode = 2'd0;
    tick();
  endtask

  task automatic test_coin();
    int low;
    low = 0;
    joy[9] = 1'b1;
    tick();
    if (coin_n[0] === 1'b0) low++;
    joy[9] = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (coin_n[0] === 1'b0) low++; end
    total++; if (low != CMIN) begin bad++; $display("FAIL coin_single got=%0d exp=%0d", low, CMIN); end
    low = 0;
    for (int i = 0; i < 25; i++) begin
      joy[9] = (i == 0 || i == 4);
      tick();
      if (coin_n[0] === 1'b0) low++;
    end
    total++; if (low != CMIN + 4) begin bad++; $display("FAIL coin_retrigger got=%0d exp=%0d", low, CMIN + 4); end
    total++; if (coin_n !== '1) begin bad++; $display("FAIL coin_idle got=%b exp=111", coin_n); end
  endtask

  task automatic test_dip();
    wr = 1'b1; idx = 8'd254; addr = 25'd0; dout = 8'hA5;
    tick();
    total++; if (dip[7:0] !== 8'hA5) begin bad++; $display("FAIL dip_byte0 got=%h exp=a5", dip[7:0]); end
    addr = 25'd1; dout = 8'h3C; tick();
    addr = 25'd9; dout = 8'hFF; tick();
    addr = 25'd2; dout = 8'h77; tick();
    idx = 8'd253; addr = 25'd0; dout = 8'h11; tick();
    wr = 1'b0; idx = 8'd0;
    total++; if (dip !== 16'h3CA5) begin bad++; $display("FAIL dip_capture got=%h exp=3ca5", dip); end
    rst = 1'b1; tick(); rst = 1'b0; tick();
    total++; if (dip !== 16'h3CA5) begin bad++; $display("FAIL dip_after_reset got=%h exp=3ca5", dip); end
  endtask

  task automatic test_pause();
    joy[16+11] = 1'b1;
    tick();
    total++; if (pause !== 1'b1) begin bad++; $display("FAIL pause_joy got=%b exp=1", pause); end
    key(8'h4D, 1'b1); tick(); tick();
    joy[16+11] = 1'b0; tick();
    total++; if (pause !== 1'b1) begin bad++; $display("FAIL pause_kbd_hold got=%b exp=1", pause); end
    key(8'h4D, 1'b0); tick();
    total++; if (pause !== 1'b1) begin bad++; $display("FAIL pause_kbd_lag got=%b exp=1", pause); end
    tick();
    total++; if (pause !== 1'b0) begin bad++; $display("FAIL pause_released got=%b exp=0", pause); end
  endtask

  task automatic test_reset_stretch();
    joy[32+9] = 1'b1; tick(); joy[32+9] = 1'b0;
    tick(); tick();
    total++; if (coin_n[2] !== 1'b0) begin bad++; $display("FAIL stretch_active got=%b exp=0", coin_n[2]); end
    rst = 1'b1; key(8'h75, 1'b1);
    tick();
    total++; if (dir_n !== '1 || btn_n !== '1 || start_n !== '1 || coin_n !== '1) begin
      bad++; $display("FAIL reset_mid_stretch got=%h/%h/%b/%b exp=all ones", dir_n, btn_n, start_n, coin_n); end
    total++; if (pause !== 1'b0) begin bad++; $display("FAIL reset_mid_pause got=%b exp=0", pause); end
    rst = 1'b0;
    tick(); tick(); tick();
    total++; if (dir_n !== '1 || coin_n !== '1) begin bad++; $display("FAIL no_key_after_reset got=%h/%b exp=fff/111", dir_n, coin_n); end
  endtask

  task automatic test_random();
    logic [7:0] codes [14] = '{8'h16, 8'h1E, 8'h2E, 8'h36, 8'h4D, 8'h75, 8'h72,
                               8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h12, 8'h00};
    logic [7:0] c;
    for (int n = 0; n < 600; n++) begin
      if (n % 60 == 0) mode = 2'($urandom);
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 2) == 0) joy[16*p +: 16] = 16'($urandom) & 16'h0BFF;
      if ($urandom_range(0, 3) == 0) begin
        c = codes[$urandom_range(0, 13)];
        if (c == 8'h00) c = 8'($urandom);
        ps2 = {~ps2[10], 1'($urandom), 1'($urandom), c};
      end
      rst  = ($urandom_range(0, 63) == 0);
      wr   = ($urandom_range(0, 7) == 0);
      idx  = $urandom_range(0, 1) ? 8'd254 : 8'($urandom);
      addr = 25'($urandom_range(0, 11));
      dout = 8'($urandom);
      tick();
      total++; if (dir_n !== e_dir_n) begin bad++; $display("FAIL rnd_dir n=%0d got=%h exp=%h", n, dir_n, e_dir_n); end
      total++; if (btn_n !== e_btn_n) begin bad++; $display("FAIL rnd_btn n=%0d got=%h exp=%h", n, btn_n, e_btn_n); end
      total++; if (start_n !== e_start_n) begin bad++; $display("FAIL rnd_start n=%0d got=%b exp=%b", n, start_n, e_start_n); end
      total++; if (coin_n !== e_coin_n) begin bad++; $display("FAIL rnd_coin n=%0d got=%b exp=%b", n, coin_n, e_coin_n); end
      total++; if (pause !== e_pause) begin bad++; $display("FAIL rnd_pause n=%0d got=%b exp=%b", n, pause, e_pause); end
      total++; if (dip !== m_dip) begin bad++; $display("FAIL rnd_dip n=%0d got=%h exp=%h", n, dip, m_dip); end
    end
    rst = 1'b0; wr = 1'b0; joy = '0;
  endtask

  initial begin
    rst = 1'b1; ps2 = '0; joy = '0; mode = 2'd0;
    wr = 1'b0; idx = '0; addr = '0; dout = '0;
    test_reset();
    test_kbd_latency();
    test_socd();
    test_coin();
    test_dip();
    test_pause();
    test_reset_stretch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
